lane_arbiter: RTL and testbench
===============================

Name: lane_arbiter

Overview:
- Round-robin arbiter that shares one registered 8-bit output lane between NUM_REQ valid/ready input streams.
- Sits in front of the top-level byte routing datapath and sequences which input drives the shared output lane.
- Grants are held for bursts of up to MAX_BURST transfers, then rotate.
- Tags each output beat with its source index.

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 2.
- DATA_WIDTH, 8, width of each data lane.
- MAX_BURST, 4, maximum consecutive transfers per grant; must be >= 1.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  NUM_REQ*DATA_WIDTH  requester data, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  NUM_REQ  per-requester valid.
- in_ready  output  NUM_REQ  per-requester ready; at most one bit set.
- out_data  output  DATA_WIDTH  registered output data.
- out_src  output  $clog2(NUM_REQ)  index of the requester that produced out_data.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, ptr = 0, grant = 0, burst_cnt = 0.
  - out_valid = 0, out_data = 0, out_src = 0, in_ready = 0.
- Reset asserted mid-burst: all state returns to these values immediately. No beat is produced from a partially handled transfer. A held out_valid beat is dropped.
- Transfer rules:
  - Input transfer on requester i: in_valid[i] & in_ready[i] at a clock edge.
  - Output transfer: out_valid & out_ready.
- Output register (single entry):
  - load = input transfer this cycle.
  - On load: out_data and out_src are updated, and out_valid = 1.
  - Else if out_ready: out_valid = 0.
  - out_data and out_src hold their values while out_valid = 0.
- IDLE state:
  - in_ready = 0.
  - If any in_valid bit is set, pick the first set index scanning ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - Register that index as grant, clear burst_cnt, and move to GRANT.
  - If no in_valid bit is set, stay in IDLE.
- GRANT state:
  - in_ready[grant] = ~out_valid | out_ready. All other in_ready bits are 0.
  - On an input transfer: burst_cnt++.
  - If burst_cnt was MAX_BURST-1 at that transfer, release the grant.
  - If in_valid[grant] = 0 in any GRANT cycle, release immediately with no transfer (withdrawal).
  - Release: ptr = (grant+1) mod NUM_REQ, then go to IDLE.
  - Stalls (out_ready low with out_valid high) hold the grant indefinitely. burst_cnt does not advance during stalls.
- Latency:
  - in_valid rising at cycle 0 with the arbiter in IDLE: in_ready high at cycle 1, provided the output register can accept.
  - The beat appears on out_data/out_valid at cycle 2.
  - Each grant release costs exactly one IDLE bubble cycle.
  - Throughput within a burst is one beat per cycle when out_ready is held high.
- Fairness:
  - A requester that stays valid is granted within NUM_REQ-1 grants of other requesters.
  - Ties are resolved only by ptr.
- Simultaneous events:
  - A release and new in_valid bits in the same cycle: the new bits are evaluated in the following IDLE cycle using the updated ptr.
  - Load and output consume in the same cycle: out_valid stays 1 and the data is replaced.
- Widths:
  - burst_cnt is $clog2(MAX_BURST+1) bits.
  - ptr and grant are $clog2(NUM_REQ) bits.
  - The ptr increment wraps explicitly at NUM_REQ; NUM_REQ need not be a power of two.

Decomposition:
- Package lane_arb_pkg:
  - State enum {IDLE, GRANT}.
  - Function next_idx(idx, n) for the modulo increment.
- Sub-module rr_pick (combinational):
  - Inputs: req[NUM_REQ], ptr.
  - Outputs: found, idx.
  - Implements the rotating first-set scan.
  - Instantiated once in lane_arbiter.

Test Plan:
- Single requester: in_valid = 4'b0100, lane 2 carries 8'hA0..8'hA5 one per beat, out_ready = 1.
  - Beats A0–A3 appear back to back with out_src = 2.
  - Then a one-cycle bubble.
  - Then A4–A5.
  - ptr = 3 after each release.
- Round robin: all four valid continuously, lane i data = 8'h10*i+beat, MAX_BURST = 4.
  - out_src sequence is 0×4, 1×4, 2×4, 3×4, 0×4.
  - Exactly one bubble between groups.
- Backpressure: req 1 granted, out_ready = 0 for 5 cycles after the first beat 8'h11.
  - out_valid stays 1 with out_data = 8'h11 stable.
  - in_ready[1] = 0 during the stall.
  - burst_cnt is unchanged.
  - On out_ready = 1, beats resume with no loss or duplication.
- Withdrawal: req 3 granted, drops in_valid after 2 beats while req 0 is valid.
  - Grant is released, ptr = 0.
  - Next grant goes to req 0.
  - Req 3 produces exactly 2 beats.
- Reset mid-burst: assert rst while out_valid = 1 in GRANT.
  - out_valid, in_ready, out_data and out_src go to 0 asynchronously, before the next edge.
  - After release, the first grant goes to the lowest valid index (ptr = 0).
- Non-power-of-two wrap: NUM_REQ = 3, req 2 is the last grant, reqs 0 and 2 valid.
  - ptr wraps to 0 and req 0 is granted next.

Source files
------------

// File: rtl/lane_arb_pkg.sv
// Shared types and helpers for the lane arbiter.
package lane_arb_pkg;

  typedef enum logic {StIdle, StGrant} state_e;

  // Modulo increment that wraps explicitly, so n need not be a power of two.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating first-set scan: finds the first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW  = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic              found_o,
  output logic [IdxW-1:0]   idx_o
);

  int unsigned       sum;
  logic [IdxW-1:0]   cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    sum     = 0;
    cand    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      sum = 32'(ptr_i) + k;
      if (sum >= NumReq) sum = sum - NumReq;
      cand = IdxW'(sum);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/lane_arbiter.sv
// Round-robin burst arbiter sharing one registered output lane between NUM_REQ streams.
module lane_arbiter
  import lane_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned IdxW      = $clog2(NUM_REQ),
  localparam int unsigned CntW      = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_valid,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IdxW-1:0]               out_src,
  output logic                          out_valid,
  input  logic                          out_ready
);

  state_e                state_q, state_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [IdxW-1:0]       grant_q, grant_d;
  logic [CntW-1:0]       burst_cnt_q, burst_cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [IdxW-1:0]       out_src_q, out_src_d;
  logic                  out_valid_q, out_valid_d;

  logic                  pick_found;
  logic [IdxW-1:0]       pick_idx;
  logic                  slot_rdy;
  logic                  load;
  logic [DATA_WIDTH-1:0] lanes [NUM_REQ];

  rr_pick #(
    .NumReq (NUM_REQ)
  ) u_rr_pick (
    .req_i   (in_valid),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      lanes[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    in_ready    = '0;
    load        = 1'b0;
    slot_rdy    = ~out_valid_q | out_ready;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = StGrant;
        end
      end
      StGrant: begin
        in_ready[grant_q] = slot_rdy;
        if (!in_valid[grant_q]) begin
          // Withdrawal: give up the grant without a transfer.
          ptr_d   = IdxW'(next_idx(32'(grant_q), NUM_REQ));
          state_d = StIdle;
        end else if (slot_rdy) begin
          load        = 1'b1;
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (burst_cnt_q == CntW'(MAX_BURST - 1)) begin
            ptr_d   = IdxW'(next_idx(32'(grant_q), NUM_REQ));
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = lanes[grant_q];
      out_src_d   = grant_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_lane_arbiter.sv
// Directed self-checking bench for lane_arbiter (4-requester and 3-requester instances).
module tb_lane_arbiter;

  logic        clk;
  logic        rst;

  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_valid;
  logic        out_ready;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_src3;
  logic        out_valid3;
  logic        out_ready3;

  logic [7:0]  base4 [4];
  logic [7:0]  beat4 [4];
  logic [7:0]  base3 [3];
  logic [7:0]  beat3 [3];

  int total = 0;
  int bad   = 0;

  lane_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  lane_arbiter #(
    .NUM_REQ    (3),
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_src   (out_src3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each source presents base + number of beats it has already handed over.
  always_comb begin
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = base4[i] + beat4[i];
    for (int i = 0; i < 3; i++) in_data3[i*8 +: 8] = base3[i] + beat3[i];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int v, input int d, input int s);
    chk({tag, "_valid"}, 32'(out_valid), v);
    chk({tag, "_data"}, 32'(out_data), d);
    chk({tag, "_src"}, 32'(out_src), s);
  endtask

  task automatic chk_out3(input string tag, input int v, input int d, input int s);
    chk({tag, "_valid"}, 32'(out_valid3), v);
    chk({tag, "_data"}, 32'(out_data3), d);
    chk({tag, "_src"}, 32'(out_src3), s);
  endtask

  // Advance one clock; sources advance their data after an accepted beat.
  task automatic step();
    logic [3:0] x4;
    logic [2:0] x3;
    #1;
    x4 = in_valid & in_ready;
    x3 = in_valid3 & in_ready3;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (x4[i]) beat4[i] = beat4[i] + 8'd1;
    for (int i = 0; i < 3; i++) if (x3[i]) beat3[i] = beat3[i] + 8'd1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_valid   = '0;
    in_valid3  = '0;
    out_ready  = 1'b1;
    out_ready3 = 1'b1;
    for (int i = 0; i < 4; i++) begin base4[i] = '0; beat4[i] = '0; end
    for (int i = 0; i < 3; i++) begin base3[i] = '0; beat3[i] = '0; end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_out("rst", 0, 0, 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_ptr", 32'(u_dut.ptr_q), 0);

    // Single requester on lane 2
    base4[2] = 8'hA0;
    in_valid = 4'b0100;
    step();
    chk("t1_first_ready", 32'(in_ready), 32'h4);
    chk("t1_no_beat_yet", 32'(out_valid), 0);
    for (int b = 0; b < 4; b++) begin
      step();
      chk_out("t1_burst", 1, 'hA0 + b, 2);
    end
    chk("t1_ptr_rel1", 32'(u_dut.ptr_q), 3);
    step();
    chk("t1_bubble", 32'(out_valid), 0);
    for (int b = 4; b < 6; b++) begin
      step();
      chk_out("t1_tail", 1, 'hA0 + b, 2);
    end
    in_valid = '0;
    step();
    chk("t1_drained", 32'(out_valid), 0);
    chk("t1_ptr_rel2", 32'(u_dut.ptr_q), 3);

    // Round robin, all four valid
    do_reset();
    for (int i = 0; i < 4; i++) base4[i] = 8'(8'h10 * i);
    in_valid = 4'hF;
    step();
    chk("t2_idle", 32'(out_valid), 0);
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 4; b++) begin
        step();
        chk_out("t2_rr", 1, 'h10 * (g % 4) + (g / 4) * 4 + b, g % 4);
      end
      if (g < 4) begin
        step();
        chk("t2_bubble", 32'(out_valid), 0);
      end
    end

    // Backpressure on requester 1
    do_reset();
    base4[1] = 8'h11;
    in_valid = 4'b0010;
    step();
    step();
    chk_out("t3_first", 1, 'h11, 1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk_out("t3_stall", 1, 'h11, 1);
      chk("t3_stall_ready", 32'(in_ready), 0);
      chk("t3_stall_cnt", 32'(u_dut.burst_cnt_q), 1);
    end
    out_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      step();
      chk_out("t3_resume", 1, 'h11 + b, 1);
    end
    step();
    chk("t3_bubble", 32'(out_valid), 0);

    // Withdrawal of requester 3 while requester 0 waits
    do_reset();
    base4[3] = 8'h30;
    base4[0] = 8'h40;
    in_valid = 4'b1000;
    step();
    in_valid = 4'b1001;
    step();
    chk_out("t4_b0", 1, 'h30, 3);
    step();
    chk_out("t4_b1", 1, 'h31, 3);
    in_valid = 4'b0001;
    step();
    chk("t4_release", 32'(out_valid), 0);
    chk("t4_ptr", 32'(u_dut.ptr_q), 0);
    step();
    chk("t4_ready0", 32'(in_ready), 32'h1);
    step();
    chk_out("t4_req0", 1, 'h40, 0);
    chk("t4_req3_beats", 32'(beat4[3]), 2);

    // Reset asserted mid-burst
    do_reset();
    base4[2] = 8'hA0;
    base4[1] = 8'h70;
    in_valid = 4'b0100;
    step();
    step();
    chk_out("t5_pre", 1, 'hA0, 2);
    rst = 1'b1;
    #1;
    chk_out("t5_async", 0, 0, 0);
    chk("t5_async_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 4'b0110;
    step();
    chk("t5_lowest_ready", 32'(in_ready), 32'h2);
    step();
    chk_out("t5_first", 1, 'h70, 1);

    // Non-power-of-two wrap on the 3-requester instance
    do_reset();
    base3[2] = 8'hC0;
    base3[0] = 8'hD0;
    in_valid3 = 3'b100;
    step();
    in_valid3 = 3'b101;
    for (int b = 0; b < 4; b++) begin
      step();
      chk_out3("t6_req2", 1, 'hC0 + b, 2);
    end
    chk("t6_ptr_wrap", 32'(u_dut3.ptr_q), 0);
    step();
    chk("t6_bubble", 32'(out_valid3), 0);
    chk("t6_ready0", 32'(in_ready3), 32'h1);
    step();
    chk_out3("t6_req0", 1, 'hD0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
